// File: rtl/axis_sync_fifo_pkg.sv
// Shared defaults and elaboration helpers for the AXI-Stream synchronous FIFO.
package axis_sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32'd8;
  localparam int unsigned DEF_DEPTH         = 32'd16;
  localparam int unsigned DEF_AFULL_THRESH  = 32'd12;
  localparam int unsigned DEF_AEMPTY_THRESH = 32'd2;

  // True when v is a power of two no smaller than 2.
  function automatic bit is_pow2(input int unsigned v);
    return (v >= 32'd2) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/axis_sync_fifo_if.sv
// AXI-Stream beat bundle (tdata/tlast/tvalid/tready) with master and slave views.
interface axis_sync_fifo_if
  import axis_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_sync_fifo_sdp_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_sdp_mem #(
  parameter int unsigned DEPTH = 32'd16,
  parameter int unsigned WIDTH = 32'd9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port: store one entry per accepted beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock FWFT FIFO with AXI-Stream handshakes; head entry held in a registered output stage.
module axis_sync_fifo
  import axis_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH         = DEF_DEPTH,
  parameter int unsigned AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     flush,
  axis_sync_fifo_if.slave          s_axis,
  axis_sync_fifo_if.master         m_axis,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   hwm,
  input  logic                     hwm_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 32'd1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AEMPTY_THRESH);
  localparam logic [CNT_W-1:0] ONE_LVL  = CNT_W'(1'b1);

  if ((DATA_WIDTH < 32'd1) || !is_pow2(DEPTH) || (AFULL_THRESH < 32'd1) ||
      (AFULL_THRESH > DEPTH) || (AEMPTY_THRESH > DEPTH - 32'd1)) begin : g_param_err
    $error("axis_sync_fifo: illegal DATA_WIDTH/DEPTH/threshold parameters");
  end

  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  logic [CNT_W-1:0]      level_r, level_next_s, hwm_r, hwm_next_s;
  logic                  s_ready_r, afull_r, aempty_r;
  logic                  m_valid_r, m_valid_next_s;
  logic [DATA_WIDTH-1:0] m_data_r, m_data_next_s;
  logic                  m_last_r, m_last_next_s;
  logic                  push_s, pop_s, mem_we_s;
  logic [DATA_WIDTH:0]   mem_rdata_s;

  assign push_s   = s_axis.tvalid & s_ready_r;
  assign pop_s    = m_valid_r & m_axis.tready;
  assign mem_we_s = push_s & ~flush;

  fifo_sdp_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH + 32'd1)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata ({s_axis.tlast, s_axis.tdata}),
    .raddr (rd_ptr_next_s),
    .rdata (mem_rdata_s)
  );

  // Next pointers and fill level; flush discards both handshakes of its cycle.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    level_next_s  = level_r;
    if (flush) begin
      wr_ptr_next_s = {PTR_W{1'b0}};
      rd_ptr_next_s = {PTR_W{1'b0}};
      level_next_s  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_next_s = wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_next_s = level_r + ONE_LVL;
        2'b01:   level_next_s = level_r - ONE_LVL;
        default: level_next_s = level_r;
      endcase
    end
  end

  // Head register reload; a beat that becomes the only entry bypasses the array.
  always_comb begin
    m_valid_next_s = (level_next_s != {CNT_W{1'b0}});
    m_data_next_s  = {DATA_WIDTH{1'b0}};
    m_last_next_s  = 1'b0;
    if (!m_valid_next_s) begin
      m_data_next_s = {DATA_WIDTH{1'b0}};
      m_last_next_s = 1'b0;
    end else if (push_s && (level_next_s == ONE_LVL)) begin
      m_data_next_s = s_axis.tdata;
      m_last_next_s = s_axis.tlast;
    end else begin
      m_data_next_s = mem_rdata_s[DATA_WIDTH-1:0];
      m_last_next_s = mem_rdata_s[DATA_WIDTH];
    end
  end

  // High-water mark tracks the post-update level; clear wins over update.
  always_comb begin
    hwm_next_s = hwm_r;
    if (hwm_clr) begin
      hwm_next_s = level_next_s;
    end else if (level_next_s > hwm_r) begin
      hwm_next_s = level_next_s;
    end else begin
      hwm_next_s = hwm_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      level_r   <= {CNT_W{1'b0}};
      hwm_r     <= {CNT_W{1'b0}};
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      m_data_r  <= {DATA_WIDTH{1'b0}};
      m_last_r  <= 1'b0;
      afull_r   <= 1'b0;
      aempty_r  <= 1'b1;
    end else begin
      wr_ptr_r  <= wr_ptr_next_s;
      rd_ptr_r  <= rd_ptr_next_s;
      level_r   <= level_next_s;
      hwm_r     <= hwm_next_s;
      s_ready_r <= (level_next_s != FULL_LVL);
      m_valid_r <= m_valid_next_s;
      m_data_r  <= m_data_next_s;
      m_last_r  <= m_last_next_s;
      afull_r   <= (level_next_s >= AF_LVL);
      aempty_r  <= (level_next_s <= AE_LVL);
    end
  end

  assign s_axis.tready = s_ready_r;
  assign m_axis.tvalid = m_valid_r;
  assign m_axis.tdata  = m_data_r;
  assign m_axis.tlast  = m_last_r;
  assign level         = level_r;
  assign hwm           = hwm_r;
  assign almost_full   = afull_r;
  assign almost_empty  = aempty_r;

endmodule
